// File: rtl/alu_instr_builder.sv
// -----------------------------------------------------------------------------
// alu_instr_builder
//
// Producer end of the ALU instruction interface. Collects a header word and
// four 32-bit operand words from a command bus, assembles them into one
// instr_t {a, b, opcode}, and issues it to the alu block over valid/ready.
//
// Ports:
//   clk          rising-edge clock
//   rstN         asynchronous active-low reset
//   word_in      command word (word32_t)
//   word_valid   word_in is valid this cycle
//   word_ready   builder accepts a word this cycle (state decode only)
//   instruction  assembled {a, b, opcode}, held stable while instr_valid
//   instr_valid  instruction is valid
//   instr_ready  alu accepts the instruction
//   div_zero     opcode==DIV and b==0, meaningful while instr_valid
//   hdr_err      one-cycle pulse when a header without SYNC_BYTE is dropped
//   instr_count  instructions issued (wraps)
//   err_count    bad headers dropped (wraps)
//
// Word order after the header: a[31:0], a[63:32], b[31:0], b[63:32].
// Header: [31:24] must equal SYNC_BYTE, [1:0] is the opcode, [23:2] ignored.
// -----------------------------------------------------------------------------

package base_types;
  typedef logic [31:0] word32_t;
  typedef logic [63:0] word64_t;
endpackage

package alu_types;
  import base_types::word32_t;
  import base_types::word64_t;
  // Users of alu_types see the base word types without importing base_types.
  export base_types::word32_t;
  export base_types::word64_t;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    MULT = 2'b10,
    DIV  = 2'b11
  } opcodes_t;

  typedef struct packed {
    word64_t  a;
    word64_t  b;
    opcodes_t opcode;
  } instr_t;
endpackage

module alu_instr_builder
  import alu_types::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  word32_t          word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output instr_t           instruction,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic             div_zero,
  output logic             hdr_err,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    HDR,
    A_LO,
    A_HI,
    B_LO,
    B_HI,
    ISSUE
  } state_t;

  state_t state_q, state_d;

  // Held low through reset and for the first cycle after release, so the
  // builder never advertises readiness while reset is asserted.
  logic   ready_en_q;

  instr_t instr_q;
  logic   div_zero_q;
  logic   hdr_err_q;

  logic   word_take;
  logic   instr_take;
  logic   hdr_ok;

  assign word_take  = word_valid && word_ready;
  assign instr_take = instr_valid && instr_ready;
  assign hdr_ok     = (word_in[31:24] == SYNC_BYTE);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR:     if (word_take && hdr_ok) state_d = A_LO;
      A_LO:    if (word_take)           state_d = A_HI;
      A_HI:    if (word_take)           state_d = B_LO;
      B_LO:    if (word_take)           state_d = B_HI;
      B_HI:    if (word_take)           state_d = ISSUE;
      ISSUE:   if (instr_take)          state_d = HDR;
      default:                          state_d = HDR;
    endcase
  end

  // Output decode: purely from registered state, no path from word_valid or
  // instr_ready into word_ready.
  always_comb begin
    word_ready  = 1'b0;
    instr_valid = 1'b0;
    if (state_q == ISSUE) begin
      instr_valid = 1'b1;
    end else begin
      word_ready  = ready_en_q;
    end
  end

  // Datapath: operand capture, flags and counters.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ready_en_q     <= 1'b0;
      instr_q.a      <= '0;
      instr_q.b      <= '0;
      instr_q.opcode <= ADD;
      div_zero_q     <= 1'b0;
      hdr_err_q      <= 1'b0;
      instr_count    <= '0;
      err_count      <= '0;
    end else begin
      ready_en_q <= 1'b1;
      // Assigned every cycle, so a dropped header yields exactly one pulse.
      hdr_err_q  <= word_take && (state_q == HDR) && !hdr_ok;

      if (word_take) begin
        unique case (state_q)
          HDR: begin
            if (hdr_ok) instr_q.opcode <= opcodes_t'(word_in[1:0]);
            else        err_count      <= err_count + CNT_W'(1);
          end
          A_LO: instr_q.a[31:0]  <= word_in;
          A_HI: instr_q.a[63:32] <= word_in;
          B_LO: instr_q.b[31:0]  <= word_in;
          B_HI: begin
            instr_q.b[63:32] <= word_in;
            // Evaluated on the full 64-bit b: the low half is already held.
            div_zero_q <= (instr_q.opcode == DIV) && (word_in == '0) &&
                          (instr_q.b[31:0] == '0);
          end
          default: ;
        endcase
      end

      if (instr_take) begin
        div_zero_q  <= 1'b0;
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  assign instruction = instr_q;
  assign div_zero    = div_zero_q;
  assign hdr_err     = hdr_err_q;

endmodule

// File: tb/tb_alu_instr_builder.sv
// -----------------------------------------------------------------------------
// tb_alu_instr_builder
//
// Self-checking bench for alu_instr_builder. The driver pushes each expected
// instruction into a queue as its words are sent; a monitor pops and compares
// on every issue transfer. A second instance with CNT_W=4 shares the stimulus
// to exercise counter wrap.
// -----------------------------------------------------------------------------

module tb_alu_instr_builder;
  import alu_types::*;

  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rstN;
  word32_t     word_in;
  logic        word_valid;
  logic        word_ready;
  instr_t      instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        div_zero;
  logic        hdr_err;
  logic [15:0] instr_count;
  logic [15:0] err_count;

  logic        w4_word_ready;
  instr_t      w4_instruction;
  logic        w4_instr_valid;
  logic        w4_div_zero;
  logic        w4_hdr_err;
  logic [3:0]  w4_instr_count;
  logic [3:0]  w4_err_count;

  alu_instr_builder #(.SYNC_BYTE(SYNC), .CNT_W(16)) dut (
    .clk(clk), .rstN(rstN), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .instruction(instruction),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .div_zero(div_zero), .hdr_err(hdr_err),
    .instr_count(instr_count), .err_count(err_count)
  );

  alu_instr_builder #(.SYNC_BYTE(SYNC), .CNT_W(4)) dut_w4 (
    .clk(clk), .rstN(rstN), .word_in(word_in), .word_valid(word_valid),
    .word_ready(w4_word_ready), .instruction(w4_instruction),
    .instr_valid(w4_instr_valid), .instr_ready(instr_ready),
    .div_zero(w4_div_zero), .hdr_err(w4_hdr_err),
    .instr_count(w4_instr_count), .err_count(w4_err_count)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;
  instr_t exp_q[$];
  int     exp_issued;
  int     rdy_mode;   // 0: always ready, 1: never ready, 2: random

  task automatic check(input string tag, input logic [129:0] got,
                       input logic [129:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // instr_ready changes just after each rising edge.
  initial begin
    instr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       instr_ready = 1'b1;
        1:       instr_ready = 1'b0;
        default: instr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard compare on issue, hold checks while stalled, and
  // counter checks on the cycle after each issue.
  logic   prev_stall;
  logic   cnt_pending;
  instr_t held_instr;
  logic   held_dz;
  instr_t e;

  always @(negedge clk) begin
    if (!rstN) begin
      prev_stall  = 1'b0;
      cnt_pending = 1'b0;
      exp_issued  = 0;
    end else begin
      if (cnt_pending) begin
        check("instr_count", 130'(instr_count), 130'(exp_issued[15:0]));
        check("instr_count_w4", 130'(w4_instr_count), 130'(exp_issued % 16));
        cnt_pending = 1'b0;
      end
      if (prev_stall) begin
        check("hold_valid", 130'(instr_valid), 130'(1));
        check("hold_instr", 130'(instruction), 130'(held_instr));
        check("hold_div_zero", 130'(div_zero), 130'(held_dz));
      end
      prev_stall = instr_valid && !instr_ready;
      held_instr = instruction;
      held_dz    = div_zero;
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 130'(instruction), 130'(0));
        end else begin
          e = exp_q.pop_front();
          check("instruction", 130'(instruction), 130'(e));
          check("div_zero", 130'(div_zero),
                130'((e.opcode == DIV) && (e.b == 64'd0)));
          check("instruction_w4", 130'(w4_instruction), 130'(e));
        end
        exp_issued++;
        cnt_pending = 1'b1;
      end
    end
  end

  // Presents one word; returns just after the edge on which it transferred.
  task automatic send_word(input word32_t w, input bit gaps);
    int n;
    bit ok;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        word_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    word_valid = 1'b1;
    word_in    = w;
    n  = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      ok = word_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    check("word_accept", 130'(ok), 130'(1));
    word_valid = 1'b0;
  endtask

  task automatic send_instr(input opcodes_t op, input word64_t a,
                            input word64_t b, input logic [21:0] mid,
                            input bit gaps);
    instr_t x;
    x.a = a;
    x.b = b;
    x.opcode = op;
    exp_q.push_back(x);
    send_word({SYNC, mid, op}, gaps);
    send_word(a[31:0], gaps);
    send_word(a[63:32], gaps);
    send_word(b[31:0], gaps);
    send_word(b[63:32], gaps);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 130'(exp_q.size()), 130'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    instr_t  e2;
    word64_t ra, rb;
    int      vcnt;

    rstN       = 1'b0;
    word_valid = 1'b0;
    word_in    = '0;
    rdy_mode   = 1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_word_ready", 130'(word_ready), 130'(0));
    check("rst_instr_valid", 130'(instr_valid), 130'(0));
    check("rst_instruction", 130'(instruction), 130'(0));
    check("rst_div_zero", 130'(div_zero), 130'(0));
    check("rst_hdr_err", 130'(hdr_err), 130'(0));
    check("rst_instr_count", 130'(instr_count), 130'(0));
    check("rst_err_count", 130'(err_count), 130'(0));
    rstN = 1'b1;
    @(posedge clk);
    #1;

    // Basic SUB with instr_ready high: valid for exactly one cycle.
    rdy_mode = 0;
    send_instr(SUB, 64'h0000_0000_1111_1111, 64'h2, 22'h0, 1'b0);
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (instr_valid) vcnt++;
    end
    check("valid_cycles", 130'(vcnt), 130'(1));
    check("count_after_first", 130'(instr_count), 130'(1));
    check("div_zero_cleared", 130'(div_zero), 130'(0));
    @(posedge clk);
    #1;

    // DIV by zero held under back-pressure.
    rdy_mode = 1;
    e2.a = 64'hCAFE_F00D_DEAD_BEEF;
    e2.b = 64'h0;
    e2.opcode = DIV;
    send_instr(DIV, e2.a, e2.b, 22'h0, 1'b0);
    repeat (10) begin
      @(negedge clk);
      check("stall_valid", 130'(instr_valid), 130'(1));
      check("stall_word_ready", 130'(word_ready), 130'(0));
      check("stall_div_zero", 130'(div_zero), 130'(1));
      check("stall_instr", 130'(instruction), 130'(e2));
    end
    check("stall_count", 130'(instr_count), 130'(1));
    @(posedge clk);
    #1;
    rdy_mode = 0;
    drain();
    check("count_after_div", 130'(instr_count), 130'(2));

    // Bad header dropped, then a good instruction.
    send_word(32'h1200_0000, 1'b0);
    @(negedge clk);
    check("hdr_err_pulse", 130'(hdr_err), 130'(1));
    check("err_count", 130'(err_count), 130'(1));
    @(negedge clk);
    check("hdr_err_single", 130'(hdr_err), 130'(0));
    @(posedge clk);
    #1;
    send_instr(MULT, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               22'h3F_FFFF, 1'b0);
    drain();
    check("count_after_mult", 130'(instr_count), 130'(3));

    // Random traffic: word gaps and random instr_ready.
    rdy_mode = 2;
    for (int i = 0; i < 100; i++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      send_instr(opcodes_t'($urandom_range(0, 3)), ra, rb,
                 22'($urandom), 1'b1);
    end
    drain();
    check("count_after_random", 130'(instr_count), 130'(103));
    check("count_w4_after_random", 130'(w4_instr_count), 130'(103 % 16));
    check("err_count_stable", 130'(err_count), 130'(1));

    // Reset in the middle of assembly discards the partial instruction.
    rdy_mode = 0;
    send_word({SYNC, 22'h0, 2'b00}, 1'b0);
    send_word(32'h5555_5555, 1'b0);
    send_word(32'hAAAA_AAAA, 1'b0);
    rstN = 1'b0;
    @(negedge clk);
    check("midrst_valid", 130'(instr_valid), 130'(0));
    check("midrst_word_ready", 130'(word_ready), 130'(0));
    check("midrst_count", 130'(instr_count), 130'(0));
    check("midrst_err_count", 130'(err_count), 130'(0));
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", 130'(instr_valid), 130'(0));
    end
    @(posedge clk);
    #1;
    send_instr(ADD, 64'h7777_0000_0000_8888, 64'h1, 22'h15_5555, 1'b0);
    drain();
    check("count_after_rst", 130'(instr_count), 130'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_instr_builder.md
Name: alu_instr_builder

Overview:
- Producer end of the ALU instruction interface.
- Accepts a stream of 32-bit words (word32_t) from a command bus and assembles them into one instr_t, which carries two 64-bit operands (word64_t) plus an opcodes_t value.
- Issues the assembled instruction to the alu block over a valid/ready handshake.
- Uses the alu_types package only; base types are reached through that package's chained export.

Parameters:
- SYNC_BYTE, 8'hA5, required value of header bits [31:24].
- CNT_W, 16, width of the issued-instruction and error counters.

Ports:
- clk  input  1  clock, rising-edge.
- rstN  input  1  reset, asynchronous, active-low.
- word_in  input  32  command word (word32_t).
- word_valid  input  1  word_in is valid this cycle.
- word_ready  output  1  builder can accept a word this cycle.
- instruction  output  instr_t (130 bits)  assembled {a, b, opcode}.
- instr_valid  output  1  instruction is valid and held stable.
- instr_ready  input  1  alu accepts the instruction.
- div_zero  output  1  qualified by instr_valid: opcode==DIV and b==0.
- hdr_err  output  1  one-cycle pulse when a bad header is dropped.
- instr_count  output  CNT_W  number of instructions issued.
- err_count  output  CNT_W  number of bad headers dropped.

Behaviour:
- Reset (rstN low, asynchronous):
  - state=HDR; word_ready=0 during reset; instr_valid=0; instruction a=0, b=0, opcode=ADD.
  - div_zero=0, hdr_err=0, instr_count=0, err_count=0.
  - Reset asserted mid-assembly or mid-issue discards the partial or pending instruction; no issue completes.
- Transfer rules:
  - A word transfers when word_valid && word_ready.
  - An instruction transfers when instr_valid && instr_ready.
- States and transitions:
  - HDR: word_ready=1. On transfer, if word_in[31:24]==SYNC_BYTE, latch opcode=word_in[1:0] and go to A_LO. Otherwise drop the word, pulse hdr_err for the next cycle only, increment err_count, and stay in HDR. Header bits [23:2] are ignored.
  - A_LO: word_ready=1. On transfer, a[31:0]=word_in; go to A_HI.
  - A_HI: word_ready=1. On transfer, a[63:32]=word_in; go to B_LO.
  - B_LO: word_ready=1. On transfer, b[31:0]=word_in; go to B_HI.
  - B_HI: word_ready=1. On transfer, b[63:32]=word_in; go to ISSUE; instr_valid=1 from the next cycle.
  - ISSUE: word_ready=0. instruction and div_zero stay stable while instr_valid=1. On instr transfer: instr_valid=0 the next cycle, instr_count+1, go to HDR.
- Handshake:
  - word_ready is a registered/state decode only; it has no combinational path from word_valid or instr_ready.
  - instr_valid never drops without a transfer.
- Latency: the last operand word transfers at edge N; instr_valid=1 after edge N. With instr_ready held high, the transfer occurs at edge N+1 and the next header can be accepted at edge N+2. Peak rate is therefore 1 instruction per 6 cycles.
- div_zero is registered when the B_HI word is captured (opcode==DIV and the full 64-bit b==0); it is cleared on issue.
- word_valid gaps in any state stall the builder without losing state.
- Counters: instr_count and err_count wrap modulo 2^CNT_W with no saturation.
- Simultaneous events: instr_ready is ignored while instr_valid=0.
- Opcode mapping is 2'b00=ADD, 01=SUB, 10=MULT, 11=DIV, per the opcodes_t encoding.

Test Plan:
- Reset, then words A5000001, 11111111, 00000000, 00000002, 00000000 with instr_ready=1 -> instruction a=64'h0000_0000_1111_1111, b=64'h2, opcode=SUB; instr_valid high for exactly 1 cycle; instr_count=1; div_zero=0.
- Header A5000003, then b words both 0, instr_ready held low for 10 cycles -> instr_valid, instruction and div_zero=1 stay stable; word_ready=0 throughout; after instr_ready=1 the issue completes and instr_count increments once.
- Header 12000000 followed by a valid header sequence -> hdr_err pulses once, err_count=1, the bad word is not used as an operand, and the following instruction is built correctly.
- Random word_valid gaps (50% duty) across 100 instructions with random instr_ready -> every instruction matches the scoreboard, in order; instr_count=100.
- rstN asserted after A_HI, then released, then a full sequence sent -> no issue from the partial instruction; the next instruction is correct.
- CNT_W=4, 17 issued instructions -> instr_count wraps to 1.
